palette_engine: RTL

PALETTE_ENGINE -- requirements
Module: palette_engine

---
 rtl/palette_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/palette_engine.sv
// Two-stage palette lookup for a VGA pixel stream, with a per-frame hit-flash that lightens colours.
// Latency 2 cycles, one pixel per cycle; no backpressure, the pipeline never stalls.
module palette_engine #(
    parameter int CW           = 4,
    parameter int IDX_W        = 3,
    parameter int FLASH_FRAMES = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              color_mode,
    input  logic [IDX_W-1:0]  color_idx,
    input  logic              pix_valid,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CW-1:0]   wr_rgb,
    input  logic              flash_start,
    input  logic              frame_tick,
    output logic [CW-1:0]     red,
    output logic [CW-1:0]     green,
    output logic [CW-1:0]     blue,
    output logic              out_valid,
    output logic              flash_active
);

    localparam int            DEPTH      = 2**IDX_W;
    localparam logic [CW-1:0] C_Z        = '0;
    localparam logic [CW-1:0] C_F        = '1;
    localparam logic [CW-1:0] C_A        = CW'(10) << (CW - 4);
    localparam logic [CW-1:0] C_GRAY     = CW'(1) << (CW - 1);
    localparam logic [7:0]    FLASH_LOAD = 8'(FLASH_FRAMES);

    // Defaults are authored at 4 bits; the all-ones nibble stays MSB-aligned for wider channels.
    function automatic logic [CW-1:0] nib_f();
        return CW'(15) << (CW - 4);
    endfunction

    function automatic logic [3*CW-1:0] pal_default(input int i);
        case (i)
            0:       return {C_Z,     nib_f(), C_Z};
            1:       return {nib_f(), C_Z,     C_Z};
            2:       return {nib_f(), nib_f(), C_Z};
            3:       return {C_Z,     C_Z,     nib_f()};
            4:       return {nib_f(), C_A,     C_Z};
            default: return {nib_f(), nib_f(), nib_f()};
        endcase
    endfunction

    // Halfway toward full scale; (C_F - c) >> 1 keeps the sum within CW bits.
    function automatic logic [CW-1:0] lighten(input logic [CW-1:0] c);
        return c + ((C_F - c) >> 1);
    endfunction

    logic [3*CW-1:0]  pal [DEPTH];
    logic             s1_vld;
    logic             s1_mode;
    logic [IDX_W-1:0] s1_idx;
    logic [7:0]       flash_cnt;
    logic [3*CW-1:0]  looked;
    logic [CW-1:0]    nxt_r, nxt_g, nxt_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pal[i] <= pal_default(i);
        end else if (wr_en) begin
            pal[wr_idx] <= wr_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_mode <= 1'b0;
            s1_idx  <= '0;
        end else begin
            s1_vld  <= pix_valid;
            s1_mode <= color_mode;
            s1_idx  <= color_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
        end else if (flash_start) begin
            flash_cnt <= FLASH_LOAD;
        end else if (frame_tick && flash_cnt != 8'd0) begin
            flash_cnt <= flash_cnt - 8'd1;
        end
    end

    assign flash_active = (flash_cnt != 8'd0);

    // Write-first: a write landing on the entry being read this cycle is seen immediately.
    assign looked = (wr_en && wr_idx == s1_idx) ? wr_rgb : pal[s1_idx];

    always_comb begin
        nxt_r = '0;
        nxt_g = '0;
        nxt_b = '0;
        if (s1_vld) begin
            if (!s1_mode) begin
                if (s1_idx == IDX_W'(0)) begin
                    nxt_r = C_Z;    nxt_g = C_Z;    nxt_b = C_Z;
                end else if (s1_idx == IDX_W'(2)) begin
                    nxt_r = C_GRAY; nxt_g = C_GRAY; nxt_b = C_GRAY;
                end else begin
                    nxt_r = C_F;    nxt_g = C_F;    nxt_b = C_F;
                end
            end else begin
                nxt_r = looked[3*CW-1:2*CW];
                nxt_g = looked[2*CW-1:CW];
                nxt_b = looked[CW-1:0];
                if (flash_active) begin
                    nxt_r = lighten(nxt_r);
                    nxt_g = lighten(nxt_g);
                    nxt_b = lighten(nxt_b);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            out_valid <= 1'b0;
        end else begin
            red       <= nxt_r;
            green     <= nxt_g;
            blue      <= nxt_b;
            out_valid <= s1_vld;
        end
    end

endmodule
